// File: rtl/alu_seq.sv
// Parametrised sequential ALU with Start/Busy/Done handshake, registered result and flags.
// Logic ops, add/sub/compare finish in one cycle; shifts step one bit per clock, multiply is shift-add.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             Start,
  input  logic [3:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   Shamt,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic             Zero,
  output logic             Negative,
  output logic             Overflow,
  output logic             CarryOut
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_MUL = 4'b1011;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [SHW:0] MUL_ITERS = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] LAST_STEP = (SHW+1)'(1);

  logic [0:0]         state;
  logic [3:0]         op_q;
  logic [SHW:0]       count;
  logic [WIDTH-1:0]   mcand;
  // Multiply: {partial product, remaining multiplier bits}; shifts use the low half only.
  logic [2*WIDTH-1:0] work;

  logic             alu_sub;
  logic [WIDTH-1:0] b_x;
  logic [WIDTH:0]   sum_full;
  logic             add_ovf;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_cout;
  logic             is_shift;
  logic             multi;

  logic [WIDTH:0]     mul_add;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH-1:0]   shift_next;
  logic [WIDTH-1:0]   fin_lo;
  logic [WIDTH-1:0]   fin_hi;
  logic               last;

  assign Busy = (state == RUN);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    alu_sub  = (Op == OP_SUB) || (Op == OP_SLT);
    b_x      = B ^ {WIDTH{alu_sub}};
    sum_full = {1'b0, A} + {1'b0, b_x} + {{WIDTH{1'b0}}, alu_sub};
    add_ovf  = (A[WIDTH-1] ^ b_x[WIDTH-1] ^ sum_full[WIDTH-1]) ^ sum_full[WIDTH];
    alu_res  = '0;
    alu_ovf  = 1'b0;
    alu_cout = 1'b0;
    case (Op)
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_NOR: alu_res = ~(A | B);
      OP_ADD, OP_SUB: begin
        alu_res  = sum_full[WIDTH-1:0];
        alu_ovf  = add_ovf;
        alu_cout = sum_full[WIDTH];
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, sum_full[WIDTH-1] ^ add_ovf};
      OP_SLL, OP_SRL, OP_SRA: alu_res = A;  // only reached with Shamt = 0
      default: alu_res = '0;
    endcase
    is_shift = (Op == OP_SLL) || (Op == OP_SRL) || (Op == OP_SRA);
    multi    = (Op == OP_MUL) || (is_shift && (Shamt != '0));
  end

  always_comb begin
    mul_add  = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, mcand} : '0);
    mul_next = {mul_add, work[WIDTH-1:1]};
    case (op_q)
      OP_SLL:  shift_next = {work[WIDTH-2:0], 1'b0};
      OP_SRA:  shift_next = {work[WIDTH-1], work[WIDTH-1:1]};
      default: shift_next = {1'b0, work[WIDTH-1:1]};
    endcase
    fin_lo = (op_q == OP_MUL) ? mul_next[WIDTH-1:0]       : shift_next;
    fin_hi = (op_q == OP_MUL) ? mul_next[2*WIDTH-1:WIDTH] : '0;
    last   = (count == LAST_STEP);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state    <= IDLE;
      op_q     <= '0;
      count    <= '0;
      mcand    <= '0;
      work     <= '0;
      Done     <= 1'b0;
      Result   <= '0;
      ResultHi <= '0;
      Zero     <= 1'b0;
      Negative <= 1'b0;
      Overflow <= 1'b0;
      CarryOut <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            if (multi) begin
              state <= RUN;
              op_q  <= Op;
              mcand <= A;
              if (Op == OP_MUL) begin
                work  <= {{WIDTH{1'b0}}, B};
                count <= MUL_ITERS;
              end else begin
                work  <= {{WIDTH{1'b0}}, A};
                count <= {1'b0, Shamt};
              end
            end else begin
              Done     <= 1'b1;
              Result   <= alu_res;
              ResultHi <= '0;
              Zero     <= (alu_res == '0);
              Negative <= alu_res[WIDTH-1];
              Overflow <= alu_ovf;
              CarryOut <= alu_cout;
            end
          end
        end
        default: begin
          count <= count - 1'b1;
          work  <= (op_q == OP_MUL) ? mul_next : {{WIDTH{1'b0}}, shift_next};
          if (last) begin
            state    <= IDLE;
            Done     <= 1'b1;
            Result   <= fin_lo;
            ResultHi <= fin_hi;
            Zero     <= ((fin_hi | fin_lo) == '0);
            Negative <= fin_lo[WIDTH-1];
            Overflow <= (fin_hi != '0);
            CarryOut <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
